// File: rtl/p3t_pkg.sv
// rtl/p3t_pkg.sv - shared types, constants and temperature encoding for the P3T sensor target
package p3t_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK,
        ST_IGNORE
    } p3t_state_e;

    localparam logic [1:0] PTR_TEMP = 2'd0;
    localparam logic [1:0] PTR_CFG  = 2'd1;

    localparam int TEMP_FRAC_BITS = 4;

    // Whole degrees to 0.0625 C/LSB: the fraction bits are always zero
    function automatic logic [11:0] temp_encode(input logic signed [7:0] t);
        return {t, {TEMP_FRAC_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronizers, edge detection and START/STOP pulses
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic scl_q1, scl_q2, scl_q3;
    logic sda_q1, sda_q2, sda_q3;

    // Two synchronizer stages plus one history stage; idle bus reads high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q1 <= 1'b1;
            scl_q2 <= 1'b1;
            scl_q3 <= 1'b1;
            sda_q1 <= 1'b1;
            sda_q2 <= 1'b1;
            sda_q3 <= 1'b1;
        end else begin
            scl_q1 <= scl_i;
            scl_q2 <= scl_q1;
            scl_q3 <= scl_q2;
            sda_q1 <= sda_i;
            sda_q2 <= sda_q1;
            sda_q3 <= sda_q2;
        end
    end

    assign scl_rise  = scl_q2 & ~scl_q3;
    assign scl_fall  = ~scl_q2 & scl_q3;
    assign sda_s     = sda_q2;
    // SDA moving while SCL is stably high marks a bus condition
    assign start_det = scl_q2 & scl_q3 & sda_q3 & ~sda_q2;
    assign stop_det  = scl_q2 & scl_q3 & ~sda_q3 & sda_q2;

endmodule

// File: rtl/p3t_sensor_target.sv
// rtl/p3t_sensor_target.sv - I2C target emulating the P3T1035/P3T2030 temperature sensor
module p3t_sensor_target
    import p3t_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR  = 7'h48,
    parameter logic [7:0] CFG_RESET = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic signed [7:0] temperature_in,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic              busy,
    output logic [7:0]        config_reg
);

    logic       scl_rise, scl_fall, sda_s, start_det, stop_det;
    p3t_state_e state, state_nxt;
    logic [7:0] shift;
    logic [7:0] shift_nxt;
    logic [2:0] bit_cnt;
    logic       last_bit;
    logic       rw;
    logic [1:0] ptr;
    logic [7:0] shadow;
    logic       byte_sel;
    logic       first_wr;
    logic       sda_oe_nxt;
    logic [15:0] rd_word;
    logic [7:0]  tx_byte;

    i2c_line_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign shift_nxt = {shift[6:0], sda_s};
    assign last_bit  = scl_rise && (bit_cnt == 3'd7);
    assign busy      = (state != ST_IDLE);

    // Read word for the current pointer; temperature comes from the snapshot
    always_comb begin
        case (ptr)
            PTR_TEMP: rd_word = {temp_encode(shadow), 4'h0};
            PTR_CFG:  rd_word = {config_reg, 8'h00};
            default:  rd_word = 16'h0000;
        endcase
        tx_byte = byte_sel ? rd_word[7:0] : rd_word[15:8];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state; bus conditions override everything; in ACK states sda_oe tells
    // whether the slot has already begun
    always_comb begin
        state_nxt = state;
        if (stop_det) begin
            state_nxt = ST_IDLE;
        end else if (start_det) begin
            state_nxt = ST_ADDR;
        end else begin
            case (state)
                ST_ADDR:      if (last_bit) state_nxt = (shift_nxt[7:1] == I2C_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                ST_ADDR_ACK:  if (scl_fall && sda_oe) state_nxt = rw ? ST_RDATA : ST_PTR;
                ST_PTR:       if (last_bit) state_nxt = ST_PTR_ACK;
                ST_PTR_ACK:   if (scl_fall && sda_oe) state_nxt = ST_WDATA;
                ST_WDATA:     if (last_bit) state_nxt = ST_WDATA_ACK;
                ST_WDATA_ACK: if (scl_fall && sda_oe) state_nxt = ST_WDATA;
                ST_RDATA:     if (last_bit) state_nxt = ST_RACK;
                ST_RACK:      if (scl_rise) state_nxt = sda_s ? ST_IGNORE : ST_RDATA;
                default:      state_nxt = state;
            endcase
        end
    end

    // SDA drive value; only moves on an SCL fall so it is stable while SCL is high
    always_comb begin
        sda_oe_nxt = 1'b0;
        if (!(stop_det || start_det)) begin
            case (state)
                ST_ADDR_ACK: begin
                    sda_oe_nxt = sda_oe;
                    if (scl_fall) sda_oe_nxt = !sda_oe ? 1'b1 : (rw ? ~tx_byte[7] : 1'b0);
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    sda_oe_nxt = sda_oe;
                    if (scl_fall) sda_oe_nxt = ~sda_oe;
                end
                ST_RDATA: begin
                    sda_oe_nxt = sda_oe;
                    if (scl_fall) sda_oe_nxt = ~tx_byte[~bit_cnt];
                end
                ST_RACK: begin
                    sda_oe_nxt = sda_oe;
                    if (scl_fall) sda_oe_nxt = 1'b0;
                end
                default: sda_oe_nxt = 1'b0;
            endcase
        end
    end

    // Shift register, bit counter, pointer, config and read snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_oe     <= 1'b0;
            shift      <= 8'h00;
            bit_cnt    <= 3'd0;
            rw         <= 1'b0;
            ptr        <= PTR_TEMP;
            config_reg <= CFG_RESET;
            shadow     <= 8'h00;
            byte_sel   <= 1'b0;
            first_wr   <= 1'b0;
        end else begin
            sda_oe <= sda_oe_nxt;
            if (start_det || stop_det) begin
                bit_cnt <= 3'd0;
            end else begin
                if (scl_rise && (state inside {ST_ADDR, ST_PTR, ST_WDATA, ST_RDATA})) begin
                    shift   <= shift_nxt;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (state == ST_ADDR && last_bit) rw <= shift_nxt[0];
                if (state == ST_PTR && last_bit) ptr <= shift_nxt[1:0];
                if (state == ST_PTR_ACK && scl_fall && sda_oe) first_wr <= 1'b1;
                if (state == ST_WDATA && last_bit) begin
                    if (first_wr && ptr == PTR_CFG) config_reg <= shift_nxt;
                    first_wr <= 1'b0;
                end
                // Snapshot taken as the read-address ACK goes out
                if (state == ST_ADDR_ACK && scl_fall && !sda_oe && rw) begin
                    shadow   <= temperature_in;
                    byte_sel <= 1'b0;
                end
                if (state == ST_RACK && scl_rise && !sda_s) byte_sel <= ~byte_sel;
            end
        end
    end

endmodule

// File: tb/tb_p3t_sensor_target.sv
// tb/tb_p3t_sensor_target.sv - scoreboard bench for the P3T sensor target
module tb_p3t_sensor_target;

    localparam int         Q    = 8;
    localparam logic [6:0] ADDR = 7'h48;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              scl = 1'b1;
    logic              sda_m = 1'b1;
    logic signed [7:0] temperature_in = 8'sd0;
    logic              sda_oe;
    logic              busy;
    logic [7:0]        config_reg;
    logic              sda_line;

    int         total = 0;
    int         bad = 0;
    logic [7:0] sb[$];
    logic [1:0] ptr_m = 2'd0;
    logic [7:0] cfg_m = 8'h00;
    bit         oe_seen = 1'b0;

    assign sda_line = sda_m & ~sda_oe;

    p3t_sensor_target #(.I2C_ADDR(ADDR), .CFG_RESET(8'h00)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .temperature_in (temperature_in),
        .scl_i          (scl),
        .sda_i          (sda_line),
        .sda_oe         (sda_oe),
        .busy           (busy),
        .config_reg     (config_reg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (sda_oe) oe_seen = 1'b1;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input bit lsb);
        logic [11:0] t12;
        t12 = {temperature_in, 4'b0000};
        case (ptr_m)
            2'd0:    return lsb ? {t12[3:0], 4'h0} : t12[11:4];
            2'd1:    return lsb ? 8'h00 : cfg_m;
            default: return 8'h00;
        endcase
    endfunction

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start(input bit lat);
        sda_m = 1'b1; wq();
        scl = 1'b1; wq();
        sda_m = 1'b0;
        if (lat) begin
            repeat (2) @(negedge clk);
            check("busy_lat_early", busy, 1'b0);
            @(negedge clk);
            check("busy_lat", busy, 1'b1);
            repeat (Q - 3) @(negedge clk);
        end else begin
            wq();
        end
        scl = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl = 1'b1; wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; wq();
        scl = 1'b1; wq(); wq();
        scl = 1'b0; wq();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        sda_m = 1'b1; wq();
        scl = 1'b1; wq();
        ack = ~sda_line;
        wq();
        scl = 1'b0; wq();
    endtask

    task automatic recv_byte(output logic [7:0] d, input bit ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wq();
            scl = 1'b1; wq();
            d[i] = sda_line;
            wq();
            scl = 1'b0; wq();
        end
        sda_m = ack ? 1'b0 : 1'b1; wq();
        scl = 1'b1; wq(); wq();
        scl = 1'b0; wq();
    endtask

    task automatic set_ptr(input logic [7:0] p, input bit lat);
        logic ack;
        i2c_start(lat);
        send_byte({ADDR, 1'b0}, ack);
        check("wr_addr_ack", ack, 1'b1);
        send_byte(p, ack);
        check("ptr_ack", ack, 1'b1);
        ptr_m = p[1:0];
    endtask

    task automatic do_read(input int n, input bit chg);
        logic       ack;
        logic [7:0] b;
        logic [7:0] e;
        for (int i = 0; i < n; i++) sb.push_back(exp_byte(i % 2 == 1));
        i2c_start(1'b0);
        check("busy_start", busy, 1'b1);
        send_byte({ADDR, 1'b1}, ack);
        check("rd_addr_ack", ack, 1'b1);
        for (int i = 0; i < n; i++) begin
            recv_byte(b, i != n - 1);
            if (chg && i == 0) temperature_in = 8'sd26;
            e = sb.pop_front();
            check($sformatf("rd_byte%0d", i), b, e);
        end
        i2c_stop();
        check("busy_stop", busy, 1'b0);
    endtask

    initial begin
        logic       ack;
        logic [7:0] a;
        repeat (3) @(negedge clk);
        check("rst_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_cfg", config_reg, 8'h00);
        rst_n = 1'b1;
        wq();

        // Pointer write, repeated START, temperature read
        temperature_in = 8'sd25;
        set_ptr(8'h00, 1'b1);
        do_read(2, 1'b0);

        // Extreme and negative values, pointer retained across transfers
        temperature_in = -8'sd10;  do_read(2, 1'b0);
        temperature_in = -8'sd128; do_read(2, 1'b0);
        temperature_in = 8'sd127;  do_read(2, 1'b0);

        // Config write: only the first data byte lands
        set_ptr(8'h01, 1'b0);
        send_byte(8'hA5, ack);
        check("cfg_data_ack", ack, 1'b1);
        cfg_m = 8'hA5;
        check("cfg_written", config_reg, cfg_m);
        send_byte(8'h3C, ack);
        check("cfg_extra_ack", ack, 1'b1);
        check("cfg_extra_ignored", config_reg, cfg_m);
        i2c_stop();
        set_ptr(8'h01, 1'b0);
        do_read(2, 1'b0);

        // Reserved register, upper pointer bits ignored
        set_ptr(8'hFE, 1'b0);
        do_read(2, 1'b0);

        // Foreign address: never drive SDA
        oe_seen = 1'b0;
        i2c_start(1'b0);
        send_byte({7'h49, 1'b0}, ack);
        check("nomatch_ack", ack, 1'b0);
        send_byte(8'h01, ack);
        i2c_stop();
        check("nomatch_oe", oe_seen, 1'b0);
        check("nomatch_cfg", config_reg, cfg_m);

        // Snapshot coherency over a 4-byte read
        temperature_in = 8'sd25;
        set_ptr(8'h00, 1'b0);
        do_read(4, 1'b1);

        // Set pointer to config, then reset during the address ACK slot
        set_ptr(8'h01, 1'b0);
        i2c_stop();
        i2c_start(1'b0);
        a = {ADDR, 1'b1};
        for (int i = 7; i >= 0; i--) send_bit(a[i]);
        sda_m = 1'b1; wq();
        scl = 1'b1; wq();
        check("oe_pre_rst", sda_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        check("oe_in_rst", sda_oe, 1'b0);
        check("busy_in_rst", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 2'd0;
        cfg_m = 8'h00;
        scl = 1'b0; wq();
        scl = 1'b1; wq(); wq();
        check("cfg_after_rst", config_reg, 8'h00);
        temperature_in = 8'sd25;
        do_read(2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
